// File: rtl/pipeline_pkg.sv
// Shared types for the writeback stage: buffered result entry and FSM state.
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        logic [XLEN-1:0] exc_num;
        logic            exc_valid;
    } wb_entry_t;

    typedef enum logic {
        WB_RUN  = 1'b0,
        WB_TRAP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order result buffer; pointers wrap naturally, count has one extra bit
// so that full and empty can be told apart.
module wb_fifo
    import pipeline_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the buffer in one edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: buffers execute results, retires them to the register
// file, turns an excepting result into a trap request plus a one-cycle flush,
// and counts retired instructions.
module writeback
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            exec_valid,
    output logic            exec_stall,
    input  logic [4:0]      exec_rd,
    input  logic [XLEN-1:0] exec_rd_val,
    input  logic [XLEN-1:0] exec_exception_num,
    input  logic            exec_exception_valid,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    input  logic            rf_wr_ready,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_num,
    input  logic            trap_ack,
    output logic            flush_out,
    output logic [63:0]     retire_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t          state;
    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_valid;
    logic               head_exc;
    logic               run_head;
    logic               retire;
    logic               push;
    logic               fifo_clear;

    assign push_entry = '{rd:        exec_rd,
                          val:       exec_rd_val,
                          exc_num:   exec_exception_num,
                          exc_valid: exec_exception_valid};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (retire),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshake and retire decisions; stall is built only from registered state
    // so execute never sees a combinational loop through its own valid.
    always_comb begin
        head_valid = !fifo_empty;
        head_exc   = head_valid && head.exc_valid;
        exec_stall = (fifo_count == CNT_W'(DEPTH)) || (state != WB_RUN) || head_exc;
        push       = exec_valid && !exec_stall && !fifo_full;
        run_head   = (state == WB_RUN) && head_valid && !head.exc_valid && !flush;
        rf_wr_en   = run_head && (head.rd != 5'd0);
        rf_wr_addr = rf_wr_en ? head.rd  : 5'd0;
        rf_wr_data = rf_wr_en ? head.val : '0;
        retire     = run_head && ((head.rd == 5'd0) || rf_wr_ready);
        fifo_clear = flush || ((state == WB_RUN) && head_exc);
    end

    // Trap FSM, flush pulse and retire counter; external flush overrides any
    // trap entry or trap exit happening in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WB_RUN;
            trap_valid   <= 1'b0;
            trap_num     <= '0;
            flush_out    <= 1'b0;
            retire_count <= '0;
        end else begin
            flush_out <= 1'b0;
            if (retire) begin
                retire_count <= retire_count + 64'd1;
            end
            if (flush) begin
                state      <= WB_RUN;
                trap_valid <= 1'b0;
            end else begin
                case (state)
                    WB_RUN: begin
                        if (head_exc) begin
                            state      <= WB_TRAP;
                            trap_valid <= 1'b1;
                            trap_num   <= head.exc_num;
                            flush_out  <= 1'b1;
                        end
                    end
                    WB_TRAP: begin
                        if (trap_ack) begin
                            state      <= WB_RUN;
                            trap_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= WB_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage, sitting on the consumer side of the execute stage's result interface. Accepts results through the execute valid/stall handshake into a small in-order buffer. Retires them to the register-file write port. Converts an excepting result into a trap request plus a one-cycle pipeline flush, and counts retired instructions.

## Interface
Parameters:
- DEPTH, 2: result buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; everything on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  external flush; discards buffered results, aborts a pending trap
- exec_valid  in  1  execute has a result
- exec_stall  out  1  writeback cannot accept; execute holds its outputs
- exec_rd  in  5  destination register
- exec_rd_val  in  32  result value
- exec_exception_num  in  32  exception cause
- exec_exception_valid  in  1  result is an exception
- rf_wr_en  out  1  register-file write request
- rf_wr_addr  out  5  write address
- rf_wr_data  out  32  write data
- rf_wr_ready  in  1  register file accepts the write this cycle
- trap_valid  out  1  trap request to the CSR/trap unit
- trap_num  out  32  trap cause
- trap_ack  in  1  trap unit has taken the trap
- flush_out  out  1  one-cycle flush to upstream stages
- retire_count  out  64  retired non-excepting results

## Operation
- Transfer occurs when exec_valid && !exec_stall; the entry {rd, val, exc_num, exc_valid} is pushed at the buffer tail.
- exec_stall = (count == DEPTH) || state != RUN || (head valid && head exception). It depends only on registered state, with no combinational path from exec_* inputs. A full buffer still stalls in a cycle it pops; there is no pass-through.
- FSM states:
  - RUN: retire from the head.
  - TRAP: hold the trap request.
- Head retirement in RUN, non-exception:
  - rd != 0: rf_wr_en=1 with head rd/val. Pop and retire_count+1 when rf_wr_ready. Otherwise hold with unchanged outputs.
  - rd == 0: no write. Pop and retire_count+1 in the same cycle.
- Head retirement in RUN, exception head:
  - No write and no count.
  - Entire buffer cleared at the clock edge.
  - trap_num ← head exc_num.
  - Next state TRAP.
  - flush_out asserted for exactly the next cycle.
- TRAP: trap_valid=1, trap_num held stable until trap_ack. On trap_ack → RUN next cycle, trap_valid drops.
- flush input, any state: buffer cleared, state → RUN, trap_valid → 0, no flush_out. This takes priority over a simultaneous exception head, push, pop, or trap_ack.
- retire_count wraps modulo 2^64 and is cleared only by reset.
- reset, including mid-trap or with a full buffer: buffer empty, RUN, retire_count=0.
- Reset values: exec_stall 0, rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0, trap_valid 0, trap_num 0, flush_out 0, retire_count 0.

## Timing
- Accept at edge N → head at N → rf_wr_en high in cycle N+1 at earliest (one-cycle latency).
- Sustained throughput is one retire per cycle with rf_wr_ready=1 and DEPTH≥2.
- Exception at head in cycle M:
  - flush_out=1 and trap_valid=1 in M+1.
  - trap_valid stays high until the cycle trap_ack is sampled.
  - Earliest new accept is in the cycle after return to RUN.
- Pointer wrap: read and write pointers are log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.

## Structure
- pipeline_pkg holds:
  - wb_entry_t (struct: rd, val, exc_num, exc_valid)
  - wb_state_t enum {WB_RUN, WB_TRAP}
  - XLEN=32
- Sub-module wb_fifo (DEPTH, entry type): synchronous FIFO with push, pop, clear, head, count, full, and empty. The top level holds the FSM, handshake, register-file port, and counter.

## Test plan
- Back-to-back: 4 results (x1=0x11, x2=0x22, x3=0x33, x4=0x44), rf_wr_ready=1 → writes in order one per cycle, first one cycle after accept, retire_count=4, exec_stall never high.
- Backpressure: rf_wr_ready=0 for 5 cycles with results offered every cycle → buffer fills, exec_stall=1 with DEPTH accepted. Writes resume in order when ready returns, with no loss or duplication.
- rd=0: result x0=0xDEAD → no rf_wr_en, retire_count+1.
- Exception: x5=5, then exception num=2, then x6=6 → x5 written. Then flush_out pulses exactly one cycle, trap_valid with trap_num=2 held for 3 cycles until trap_ack, x6 never written, accepting resumes afterward.
- Flush priority: flush asserted in the same cycle as an exception head, and separately during TRAP → buffer empty, trap_valid=0, no flush_out, state RUN.
- Reset mid-operation: reset with a full buffer in TRAP → all outputs at reset values next cycle, retire_count=0.
